// File: rtl/mc_control_unit.sv
// Multi-cycle femtoRV32 control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory.
// Latency (mem_ready high): branch 3, ALU/jump/store 4, load 5 cycles; +1 per stall cycle.
// Backpressure: holds mem_req in FETCH/MEM until mem_ready; faults after MEM_TIMEOUT stalls.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   inst[6:0]         - IR[6:0] from memory read data, captured with ir_write
//   mem_ready         - memory completes the current access this cycle
//   mem_req/mem_we/i_or_d      - memory request, store strobe, address select
//   ir_write/pc_write/pc_src   - IR load, unconditional PC write, PC source
//   Branch/ALUOp/ALUSrcA/ALUSrc - datapath compare enable and ALU operand/op selects
//   MemtoReg/RegWrite          - register file write source and enable
//   halt/fault                 - sticky terminal status
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] inst,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       halt,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       opc;
  logic             timeout;

  assign opc     = op_q[6:2];
  assign timeout = (cnt_q == TIMEOUT);

  // Next-state, opcode capture and wait counter
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (state_q == S_FETCH) begin
            op_d    = inst;
            state_d = S_DECODE;
          end else begin
            state_d = (opc == OP_STORE) ? S_FETCH : S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end else if (cnt_q != '1) begin
          // Saturate rather than wrap in case MEM_TIMEOUT sits at the counter limit
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (op_q[1:0] != 2'b11) begin
          state_d = S_FAULT;
        end else begin
          case (opc)
            OP_SYSTEM: state_d = S_HALT;
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
            OP_IMM, OP_R, OP_AUIPC, OP_LUI: state_d = S_EXEC;
            default:   state_d = S_FAULT;
          endcase
        end
      end
      S_EXEC: begin
        cnt_d = '0;  // clear on the way into FETCH or MEM
        case (opc)
          OP_BRANCH:         state_d = S_FETCH;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_WB: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      default: state_d = state_q;  // HALT and FAULT absorb until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs; only FETCH/MEM look at mem_ready. Reset forces everything low
  // so an access in flight is dropped with no enable firing.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    i_or_d   = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 2'b00;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    ALUSrcA  = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    halt     = 1'b0;
    fault    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (opc)
            OP_BRANCH: begin
              Branch = 1'b1;
              ALUOp  = 2'b01;
              pc_src = 2'b01;
            end
            OP_LOAD, OP_STORE: ALUSrc = 1'b1;
            OP_R:              ALUOp  = 2'b10;
            OP_IMM: begin
              ALUOp  = 2'b11;
              ALUSrc = 1'b1;
            end
            OP_LUI: begin
              ALUSrcA = 2'b10;
              ALUSrc  = 1'b1;
            end
            OP_AUIPC: begin
              ALUSrcA = 2'b01;
              ALUSrc  = 1'b1;
            end
            OP_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
            end
            OP_JALR: begin
              ALUSrc   = 1'b1;
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          ALUSrc  = 1'b1;
          mem_we  = (opc == OP_STORE);
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (opc == OP_LOAD)                        MemtoReg = 2'b01;
          else if (opc == OP_JAL || opc == OP_JALR)  MemtoReg = 2'b10;
          else                                       MemtoReg = 2'b00;
        end
        S_HALT:  halt  = 1'b1;
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed per-cycle vectors feed an expected-output queue,
// a negedge monitor pops and compares every presented output cycle.
module tb_mc_control_unit;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       br;
    logic [1:0] aluop;
    logic [1:0] srca;
    logic       alusrc;
    logic [1:0] mtr;
    logic       regw;
    logic       halt;
    logic       fault;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] inst;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, Branch, ALUSrc, RegWrite, halt, fault;
  logic [1:0] pc_src, ALUOp, ALUSrcA, MemtoReg;
  out_t       act;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  localparam logic [6:0] I_ADD   = 7'b0110011;
  localparam logic [6:0] I_LW    = 7'b0000011;
  localparam logic [6:0] I_SW    = 7'b0100011;
  localparam logic [6:0] I_BEQ   = 7'b1100011;
  localparam logic [6:0] I_JALR  = 7'b1100111;
  localparam logic [6:0] I_JAL   = 7'b1101111;
  localparam logic [6:0] I_ADDI  = 7'b0010011;
  localparam logic [6:0] I_LUI   = 7'b0110111;
  localparam logic [6:0] I_AUIPC = 7'b0010111;
  localparam logic [6:0] I_ECALL = 7'b1110011;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .Branch(Branch), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .halt(halt), .fault(fault)
  );

  assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, Branch,
                ALUOp, ALUSrcA, ALUSrc, MemtoReg, RegWrite, halt, fault};

  // Hand-written expected vectors for each control step
  function automatic out_t o_zero();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction
  function automatic out_t o_ex(input logic [1:0] aluop, input logic [1:0] srca, input logic alusrc,
                                input logic br, input logic pcw, input logic [1:0] pcs);
    out_t o = '0;
    o.aluop = aluop; o.srca = srca; o.alusrc = alusrc; o.br = br; o.pc_write = pcw; o.pc_src = pcs;
    return o;
  endfunction
  function automatic out_t o_mem(input logic store);
    out_t o = '0;
    o.mem_req = 1'b1; o.i_or_d = 1'b1; o.alusrc = 1'b1; o.mem_we = store;
    return o;
  endfunction
  function automatic out_t o_wb(input logic [1:0] mtr);
    out_t o = '0;
    o.regw = 1'b1; o.mtr = mtr;
    return o;
  endfunction
  function automatic out_t o_halt();
    out_t o = '0;
    o.halt = 1'b1;
    return o;
  endfunction
  function automatic out_t o_fault();
    out_t o = '0;
    o.fault = 1'b1;
    return o;
  endfunction

  // One cycle of stimulus: drive inputs, queue the outputs required this cycle
  task automatic step(input logic [6:0] i, input logic rdy, input logic r, input out_t e, input string tag);
    inst = i; mem_ready = rdy; rst = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  // Monitor: compare at mid-cycle whenever an expectation is pending
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %b required %b (t=%0t)", t, act, e, $time);
      end
    end
  end

  initial begin
    rst = 1'b1; inst = '0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset holds everything low, even with a ready memory
    step(I_ADD, 1'b1, 1'b1, o_zero(), "reset0");
    step(I_ADD, 1'b1, 1'b1, o_zero(), "reset1");

    // ADD: 4 cycles
    step(I_ADD, 1'b1, 1'b0, o_fetch(1'b1), "add_fetch");
    step('0,    1'b0, 1'b0, o_zero(), "add_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), "add_exec");
    step('0,    1'b0, 1'b0, o_wb(2'b00), "add_wb");

    // LW with 3 stall cycles in MEM: 8 cycles
    step(I_LW, 1'b1, 1'b0, o_fetch(1'b1), "lw_fetch");
    step('0,   1'b0, 1'b0, o_zero(), "lw_decode");
    step('0,   1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00), "lw_exec");
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0, o_mem(1'b0), "lw_mem_stall");
    step('0,   1'b1, 1'b0, o_mem(1'b0), "lw_mem_done");
    step('0,   1'b0, 1'b0, o_wb(2'b01), "lw_wb");

    // SW, BEQ, JALR back to back
    step(I_SW, 1'b1, 1'b0, o_fetch(1'b1), "sw_fetch");
    step('0,   1'b0, 1'b0, o_zero(), "sw_decode");
    step('0,   1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00), "sw_exec");
    step('0,   1'b1, 1'b0, o_mem(1'b1), "sw_mem");
    step(I_BEQ, 1'b1, 1'b0, o_fetch(1'b1), "beq_fetch");
    step('0,    1'b0, 1'b0, o_zero(), "beq_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01), "beq_exec");
    step(I_JALR, 1'b1, 1'b0, o_fetch(1'b1), "jalr_fetch");
    step('0,     1'b0, 1'b0, o_zero(), "jalr_decode");
    step('0,     1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10), "jalr_exec");
    step('0,     1'b0, 1'b0, o_wb(2'b10), "jalr_wb");

    // Remaining EXEC decodes: JAL, OP-IMM, LUI, AUIPC
    step(I_JAL, 1'b1, 1'b0, o_fetch(1'b1), "jal_fetch");
    step('0,    1'b0, 1'b0, o_zero(), "jal_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11), "jal_exec");
    step('0,    1'b0, 1'b0, o_wb(2'b10), "jal_wb");
    step(I_ADDI, 1'b1, 1'b0, o_fetch(1'b1), "addi_fetch");
    step('0,     1'b0, 1'b0, o_zero(), "addi_decode");
    step('0,     1'b0, 1'b0, o_ex(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00), "addi_exec");
    step('0,     1'b0, 1'b0, o_wb(2'b00), "addi_wb");
    step(I_LUI, 1'b1, 1'b0, o_fetch(1'b1), "lui_fetch");
    step('0,    1'b0, 1'b0, o_zero(), "lui_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00), "lui_exec");
    step('0,    1'b0, 1'b0, o_wb(2'b00), "lui_wb");
    step(I_AUIPC, 1'b1, 1'b0, o_fetch(1'b1), "auipc_fetch");
    step('0,      1'b0, 1'b0, o_zero(), "auipc_decode");
    step('0,      1'b0, 1'b0, o_ex(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00), "auipc_exec");
    step('0,      1'b0, 1'b0, o_wb(2'b00), "auipc_wb");

    // Fetch timeout: 16 unanswered FETCH cycles, then sticky fault
    for (int k = 0; k < 16; k++) step(I_ADD, 1'b0, 1'b0, o_fetch(1'b0), "to_fetch_wait");
    step(I_ADD, 1'b1, 1'b0, o_fault(), "to_fault0");
    step(I_ADD, 1'b1, 1'b0, o_fault(), "to_fault1");
    step(I_ADD, 1'b0, 1'b1, o_zero(), "to_reset");

    // Ready on the 16th cycle wins over the timeout
    for (int k = 0; k < 15; k++) step(I_ADD, 1'b0, 1'b0, o_fetch(1'b0), "edge_fetch_wait");
    step(I_ADD, 1'b1, 1'b0, o_fetch(1'b1), "edge_fetch_ready");
    step('0,    1'b0, 1'b0, o_zero(), "edge_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), "edge_exec");
    step('0,    1'b0, 1'b0, o_wb(2'b00), "edge_wb");

    // MEM timeout on a load
    step(I_LW, 1'b1, 1'b0, o_fetch(1'b1), "memto_fetch");
    step('0,   1'b0, 1'b0, o_zero(), "memto_decode");
    step('0,   1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00), "memto_exec");
    for (int k = 0; k < 16; k++) step('0, 1'b0, 1'b0, o_mem(1'b0), "memto_wait");
    step('0, 1'b1, 1'b0, o_fault(), "memto_fault");
    step('0, 1'b0, 1'b1, o_zero(), "memto_reset");

    // Illegal opcodes and SYSTEM
    step(7'b0000000, 1'b1, 1'b0, o_fetch(1'b1), "ill0_fetch");
    step('0, 1'b0, 1'b0, o_zero(), "ill0_decode");
    step('0, 1'b1, 1'b0, o_fault(), "ill0_fault0");
    step('0, 1'b1, 1'b0, o_fault(), "ill0_fault1");
    step('0, 1'b0, 1'b1, o_zero(), "ill0_reset");
    step(7'b1111111, 1'b1, 1'b0, o_fetch(1'b1), "ill1_fetch");
    step('0, 1'b0, 1'b0, o_zero(), "ill1_decode");
    step('0, 1'b1, 1'b0, o_fault(), "ill1_fault");
    step('0, 1'b0, 1'b1, o_zero(), "ill1_reset");
    step(I_ECALL, 1'b1, 1'b0, o_fetch(1'b1), "sys_fetch");
    step('0, 1'b0, 1'b0, o_zero(), "sys_decode");
    for (int k = 0; k < 3; k++) step(I_ADD, 1'b1, 1'b0, o_halt(), "sys_halt");
    step('0, 1'b1, 1'b1, o_zero(), "sys_reset");
    step('0, 1'b0, 1'b0, o_fetch(1'b0), "sys_after_fetch");

    // Reset during the MEM cycle of a store aborts the access
    step(I_SW, 1'b1, 1'b0, o_fetch(1'b1), "rmem_fetch");
    step('0,   1'b0, 1'b0, o_zero(), "rmem_decode");
    step('0,   1'b0, 1'b0, o_ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00), "rmem_exec");
    step(I_SW, 1'b1, 1'b1, o_zero(), "rmem_reset");
    step(I_BEQ, 1'b0, 1'b0, o_fetch(1'b0), "rmem_after_fetch");
    step(I_BEQ, 1'b1, 1'b0, o_fetch(1'b1), "rmem_beq_fetch");
    step('0,    1'b0, 1'b0, o_zero(), "rmem_beq_decode");
    step('0,    1'b0, 1'b0, o_ex(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01), "rmem_beq_exec");
    step('0,    1'b0, 1'b0, o_fetch(1'b0), "rmem_end_fetch");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
